// File: rtl/loader_pkg.sv
// Shared types and constants for the UART program loader.
// The header and data words both use the same 4-byte packing.
package loader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StHdr,
    StData,
    StWr,
    StFin,
    StErr
  } state_e;

  localparam int unsigned HDR_BYTES  = 4;
  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned BYTE_CNT_W = $clog2(HDR_BYTES);

endpackage

// File: rtl/byte_packer.sv
// Shift-in register assembling little-endian bytes into a 32-bit word.
// Shared between header and data collection.
module byte_packer
  import loader_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clr_i,
  input  logic        load_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        last_o
);

  localparam logic [BYTE_CNT_W-1:0] CntOne  = BYTE_CNT_W'(1);
  localparam logic [BYTE_CNT_W-1:0] CntLast = BYTE_CNT_W'(WORD_BYTES - 1);

  logic [31:0]           word_q, word_d;
  logic [BYTE_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    if (clr_i) begin
      word_d = '0;
      cnt_d  = '0;
    end else if (load_i) begin
      word_d = {byte_i, word_q[31:8]};
      cnt_d  = cnt_q + CntOne;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
    end
  end

  // Complete word including the byte being loaded; meaningful when load_i && last_o.
  assign word_o = {byte_i, word_q[31:8]};
  assign last_o = (cnt_q == CntLast);

endmodule

// File: rtl/uart_program_loader.sv
// Drains the UART RX FIFO and writes a length-prefixed little-endian
// program image into instruction memory.
module uart_program_loader
  import loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 14
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic                  rx_empty_i,
  output logic                  rx_rdreq_o,
  input  logic [7:0]            rx_data_i,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [31:0]           mem_wdata_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
);

  localparam logic [32:0]           Capacity = 33'(1) << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] AddrOne  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   WcntOne  = (ADDR_WIDTH + 1)'(1);

  state_e                state_q, state_d;
  logic                  pend_q, pend_d;
  logic [31:0]           n_q, n_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   wcnt_q, wcnt_d;

  logic        pk_clr;
  logic        pk_last;
  logic [31:0] pk_word;

  byte_packer u_byte_packer (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (pk_clr),
    .load_i (pend_q),
    .byte_i (rx_data_i),
    .word_o (pk_word),
    .last_o (pk_last)
  );

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    wdata_d    = wdata_q;
    addr_d     = addr_q;
    wcnt_d     = wcnt_q;
    pk_clr     = 1'b0;
    rx_rdreq_o = 1'b0;
    mem_we_o   = 1'b0;
    busy_o     = 1'b0;
    done_o     = 1'b0;
    err_o      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StHdr;
          pk_clr  = 1'b1;
          addr_d  = '0;
          wcnt_d  = '0;
        end
      end
      StHdr: begin
        busy_o     = 1'b1;
        rx_rdreq_o = !rx_empty_i && !pend_q;
        if (pend_q && pk_last) begin
          n_d = pk_word;
          // Full 32-bit compare so huge counts cannot alias into range.
          if (pk_word == '0) begin
            state_d = StFin;
          end else if ({1'b0, pk_word} > Capacity) begin
            state_d = StErr;
          end else begin
            state_d = StData;
          end
        end
      end
      StData: begin
        busy_o     = 1'b1;
        rx_rdreq_o = !rx_empty_i && !pend_q;
        if (pend_q && pk_last) begin
          wdata_d = pk_word;
          state_d = StWr;
        end
      end
      StWr: begin
        busy_o   = 1'b1;
        mem_we_o = 1'b1;
        addr_d   = addr_q + AddrOne;
        wcnt_d   = wcnt_q + WcntOne;
        if (32'(wcnt_d) == n_q) begin
          state_d = StFin;
        end else begin
          state_d = StData;
        end
      end
      StFin: begin
        done_o  = 1'b1;
        state_d = StIdle;
      end
      StErr: begin
        err_o   = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    pend_d = rx_rdreq_o;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      pend_q  <= 1'b0;
      n_q     <= '0;
      wdata_q <= '0;
      addr_q  <= '0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      n_q     <= n_d;
      wdata_q <= wdata_d;
      addr_q  <= addr_d;
      wcnt_q  <= wcnt_d;
    end
  end

  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;

endmodule

// File: tb/tb_uart_program_loader.sv
// Randomised bench for uart_program_loader with a byte-stream FIFO model
// and an image-level reference model of the expected memory writes.
module tb_uart_program_loader;

  localparam int unsigned AW  = 4;
  localparam int unsigned CAP = 1 << AW;

  logic          clk_i      = 1'b0;
  logic          rst_ni     = 1'b0;
  logic          start_i    = 1'b0;
  logic          rx_empty_i = 1'b1;
  logic [7:0]    rx_data_i  = 8'h00;
  logic          rx_rdreq_o;
  logic          mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [31:0]   mem_wdata_o;
  logic          busy_o;
  logic          done_o;
  logic          err_o;

  uart_program_loader #(.ADDR_WIDTH(AW)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .start_i     (start_i),
    .rx_empty_i  (rx_empty_i),
    .rx_rdreq_o  (rx_rdreq_o),
    .rx_data_i   (rx_data_i),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o)
  );

  always #5 clk_i = ~clk_i;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  function automatic void chk(string name, longint act, longint exp);
    vec_cnt++;
    if (act != exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  logic [7:0]    src_q[$];
  logic [7:0]    fifo_q[$];
  logic [AW-1:0] exp_addr_q[$];
  logic [31:0]   exp_data_q[$];
  logic [31:0]   log_q[$];
  logic [31:0]   fast_log[$];

  int gap = 0, gap_cnt = 0, cyc = 0;
  bit exp_err, n_zero, active, finished, complete, prev_rd, pop_due;
  int start_cyc, fin_cyc, rd_cnt, exp_rd, last_rd_cyc, last_we_cyc;

  function automatic void check_cycle();
    if (finished && cyc > fin_cyc) begin
      active   = 1'b0;
      finished = 1'b0;
    end
    if (rx_rdreq_o) begin
      chk("rdreq_nonempty", rx_empty_i, 0);
      chk("rdreq_spacing", prev_rd, 0);
      chk("rdreq_busy", busy_o, 1);
      rd_cnt++;
      last_rd_cyc = cyc;
      pop_due     = 1'b1;
    end
    prev_rd = rx_rdreq_o;
    if (mem_we_o) begin
      if (exp_data_q.size() == 0) chk("unexpected_we", 1, 0);
      else begin
        chk("we_addr", mem_addr_o, exp_addr_q.pop_front());
        chk("we_data", mem_wdata_o, exp_data_q.pop_front());
      end
      chk("we_latency", cyc - last_rd_cyc, 2);
      log_q.push_back(mem_wdata_o);
      last_we_cyc = cyc;
    end
    if (done_o || err_o) begin
      chk("pulse_when_active", active && !finished, 1);
      chk("pulse_kind_err", err_o, exp_err);
      chk("pulse_both", done_o && err_o, 0);
      chk("writes_left", exp_data_q.size(), 0);
      chk("bytes_read", rd_cnt, exp_rd);
      if (!exp_err && !n_zero) chk("done_after_wr", cyc - last_we_cyc, 1);
      else chk("pulse_after_hdr", cyc - last_rd_cyc, 2);
      finished = 1'b1;
      complete = 1'b1;
      fin_cyc  = cyc;
    end
    chk("busy", busy_o, active && !finished && cyc > start_cyc);
  endfunction

  // FIFO model: pops land one cycle after rdreq; bytes from src_q are released
  // all at once (gap=0) or one every `gap` cycles.
  always @(posedge clk_i) begin
    cyc++;
    #1;
    if (pop_due && fifo_q.size() > 0) rx_data_i = fifo_q.pop_front();
    pop_due = 1'b0;
    if (src_q.size() > 0) begin
      if (gap == 0) begin
        while (src_q.size() > 0) fifo_q.push_back(src_q.pop_front());
      end else if (gap_cnt == 0) begin
        fifo_q.push_back(src_q.pop_front());
        gap_cnt = gap;
      end
    end
    if (gap_cnt > 0) gap_cnt--;
    rx_empty_i = (fifo_q.size() == 0);
    #1;
    if (rst_ni) check_cycle();
  end

  function automatic void push_word(logic [31:0] w);
    for (int b = 0; b < 4; b++) src_q.push_back(w[8*b +: 8]);
  endfunction

  // Reference model: the image is N then N words; anything above capacity is
  // rejected after the header alone.
  task automatic begin_load(input logic [31:0] n, input logic [31:0] words[$], input bit junk);
    exp_addr_q.delete();
    exp_data_q.delete();
    log_q.delete();
    exp_err = ({1'b0, n} > 33'(CAP));
    n_zero  = (n == 0);
    exp_rd  = (exp_err || n_zero) ? 4 : 4 + 4 * int'(n);
    if (!exp_err) begin
      for (int i = 0; i < int'(n); i++) begin
        exp_addr_q.push_back(AW'(i));
        exp_data_q.push_back(words[i]);
      end
    end
    push_word(n);
    foreach (words[i]) push_word(words[i]);
    if (junk) for (int i = 0; i < 4; i++) src_q.push_back(8'($urandom));
    rd_cnt   = 0;
    complete = 1'b0;
    @(posedge clk_i);
    #1;
    start_i   = 1'b1;
    active    = 1'b1;
    finished  = 1'b0;
    start_cyc = cyc;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (!complete && k < budget) begin
      @(posedge clk_i);
      k++;
    end
    chk("completion_timeout", complete, 1);
    repeat (20) @(posedge clk_i);
    chk("no_read_after", rd_cnt, exp_rd);
    #3;
    fifo_q.delete();
    src_q.delete();
    rx_empty_i = 1'b1;
    complete   = 1'b0;
  endtask

  task automatic check_reset_outputs();
    chk("rst_rdreq", rx_rdreq_o, 0);
    chk("rst_we", mem_we_o, 0);
    chk("rst_addr", mem_addr_o, 0);
    chk("rst_wdata", mem_wdata_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_err", err_o, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] w_q[$];
    logic [31:0] empty_q[$];
    int k;

    repeat (3) @(posedge clk_i);
    #3;
    check_reset_outputs();
    rst_ni = 1'b1;
    repeat (2) @(posedge clk_i);

    // Reference image; the model itself is pinned to hand-computed values.
    gap = 0;
    w_q = '{32'hDEADBEEF, 32'h00000013};
    begin_load(32'd2, w_q, 1'b0);
    chk("model_w0", exp_data_q[0], 32'hDEADBEEF);
    chk("model_w1", exp_data_q[1], 32'h00000013);
    chk("model_a1", exp_addr_q[1], 1);
    chk("model_rd", exp_rd, 12);
    wait_done(500);
    chk("log0_literal", log_q.size() > 0 ? log_q[0] : 32'h0, 32'hDEADBEEF);
    fast_log = log_q;

    // Same image trickled in slowly.
    gap = 40;
    begin_load(32'd2, w_q, 1'b0);
    wait_done(3000);
    chk("trickle_len", log_q.size(), fast_log.size());
    foreach (fast_log[i]) chk("trickle_word", log_q.size() > i ? log_q[i] : 32'hx, fast_log[i]);
    gap = 0;

    // Empty image and oversize headers, each followed by junk that must stay unread.
    begin_load(32'd0, empty_q, 1'b1);
    wait_done(500);
    begin_load(32'(CAP + 1), empty_q, 1'b1);
    wait_done(500);
    begin_load(32'h8000_0010, empty_q, 1'b1);
    wait_done(500);

    // Exactly full memory.
    w_q.delete();
    for (int i = 0; i < int'(CAP); i++) w_q.push_back($urandom);
    begin_load(32'(CAP), w_q, 1'b0);
    wait_done(2000);

    // Random images, alternating fast and gappy feeds.
    for (int r = 0; r < 6; r++) begin
      w_q.delete();
      k = $urandom_range(1, 6);
      for (int i = 0; i < k; i++) w_q.push_back($urandom);
      gap = (r % 2 == 1) ? $urandom_range(2, 7) : 0;
      begin_load(32'(k), w_q, 1'b0);
      wait_done(2000);
    end
    gap = 0;

    // Extra start mid-load must change nothing.
    w_q = '{$urandom, $urandom, $urandom};
    begin_load(32'd3, w_q, 1'b0);
    repeat (9) @(posedge clk_i);
    #1;
    start_i = 1'b1;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    wait_done(500);

    // Asynchronous reset after two data bytes of word 0.
    w_q = '{32'h11223344, 32'h55667788};
    begin_load(32'd2, w_q, 1'b0);
    k = 0;
    while (rd_cnt < 6 && k < 200) begin
      @(posedge clk_i);
      k++;
    end
    chk("reach_data_bytes", rd_cnt >= 6, 1);
    repeat (2) @(posedge clk_i);
    #3;
    rst_ni = 1'b0;
    #1;
    check_reset_outputs();
    active   = 1'b0;
    finished = 1'b0;
    complete = 1'b0;
    prev_rd  = 1'b0;
    pop_due  = 1'b0;
    fifo_q.delete();
    src_q.delete();
    exp_addr_q.delete();
    exp_data_q.delete();
    rx_empty_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #3;
    rst_ni = 1'b1;
    w_q = '{32'hCAFEF00D};
    begin_load(32'd1, w_q, 1'b0);
    wait_done(500);
    chk("post_reset_word", log_q.size() > 0 ? log_q[0] : 32'h0, 32'hCAFEF00D);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
